// File: rtl/frodo_mac_lane4.sv
// Four-lane multiply-accumulate stage: per-lane dot products mod 2^16, results
// masked to LOGQ bits and handed downstream through a one-entry valid/ready buffer.
module frodo_mac_lane4 #(
    parameter int LOGQ  = 16,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_pos,
    input  logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [7:0]       short_data_0,
    input  logic [7:0]       short_data_1,
    input  logic [7:0]       short_data_2,
    input  logic [7:0]       short_data_3,
    input  logic [15:0]      long_data_0,
    input  logic [15:0]      long_data_1,
    input  logic [15:0]      long_data_2,
    input  logic [15:0]      long_data_3,
    input  logic [63:0]      init_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [15:0] LANE_MASK = 16'((32'd1 << LOGQ) - 32'd1);

    logic [3:0][15:0]  r_acc;
    logic [63:0]       r_out_data;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic [3:0][7:0]   w_short;
    logic [3:0][15:0]  w_long;
    logic [3:0][15:0]  w_init;
    logic [3:0][15:0]  w_sum;
    logic [63:0]       w_result;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_clear;
    logic [CNT_W-1:0]  w_cnt_next;

    assign w_short = {short_data_3, short_data_2, short_data_1, short_data_0};
    assign w_long  = {long_data_3, long_data_2, long_data_1, long_data_0};
    assign w_init  = init_data;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [15:0] w_sext;
        logic [15:0] w_prod;
        logic [15:0] w_base;

        assign w_sext   = {{8{w_short[g][7]}}, w_short[g]};
        // Only the low 16 product bits matter since everything wraps mod 2^16.
        assign w_prod   = w_sext * w_long[g];
        assign w_base   = in_first ? w_init[g] : r_acc[g];
        assign w_sum[g] = w_base + w_prod;
    end

    assign w_result   = w_sum & {4{LANE_MASK}};
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_clear    = start_pos || done;
    assign w_cnt_next = in_first    ? CNT_W'(1)  :
                        &r_beat_cnt ? r_beat_cnt : r_beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_beat_cnt  <= '0;
        end else if (w_clear) begin
            // Clear wins over any beat presented in the same cycle.
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (in_last) begin
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_beat_cnt  <= '0;
                end else begin
                    r_acc       <= w_sum;
                    r_beat_cnt  <= w_cnt_next;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_frodo_mac_lane4.sv
// Directed bench for frodo_mac_lane4; a LOGQ=15 instance shares the inputs
// so the output mask can be checked alongside the full-width instance.
module tb_frodo_mac_lane4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_pos, done, in_valid, in_first, in_last, out_ready;
    logic [7:0]  short_data_0, short_data_1, short_data_2, short_data_3;
    logic [15:0] long_data_0, long_data_1, long_data_2, long_data_3;
    logic [63:0] init_data;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [11:0] beat_cnt;
    logic        in_ready15, out_valid15;
    logic [63:0] out_data15;
    logic [11:0] beat_cnt15;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frodo_mac_lane4 #(.LOGQ(16), .CNT_W(12)) dut (
        .clk(clk), .rstn(rstn), .start_pos(start_pos), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .short_data_0(short_data_0), .short_data_1(short_data_1),
        .short_data_2(short_data_2), .short_data_3(short_data_3),
        .long_data_0(long_data_0), .long_data_1(long_data_1),
        .long_data_2(long_data_2), .long_data_3(long_data_3),
        .init_data(init_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .beat_cnt(beat_cnt)
    );

    frodo_mac_lane4 #(.LOGQ(15), .CNT_W(12)) dut15 (
        .clk(clk), .rstn(rstn), .start_pos(start_pos), .done(done),
        .in_valid(in_valid), .in_ready(in_ready15), .in_first(in_first), .in_last(in_last),
        .short_data_0(short_data_0), .short_data_1(short_data_1),
        .short_data_2(short_data_2), .short_data_3(short_data_3),
        .long_data_0(long_data_0), .long_data_1(long_data_1),
        .long_data_2(long_data_2), .long_data_3(long_data_3),
        .init_data(init_data), .out_valid(out_valid15), .out_ready(out_ready),
        .out_data(out_data15), .beat_cnt(beat_cnt15)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic first, input logic last, input logic [31:0] sh,
                            input logic [63:0] lg, input logic [63:0] init);
        in_valid     = 1'b1;
        in_first     = first;
        in_last      = last;
        short_data_0 = sh[7:0];
        short_data_1 = sh[15:8];
        short_data_2 = sh[23:16];
        short_data_3 = sh[31:24];
        long_data_0  = lg[15:0];
        long_data_1  = lg[31:16];
        long_data_2  = lg[47:32];
        long_data_3  = lg[63:48];
        init_data    = init;
    endtask

    task automatic beat(input logic first, input logic last, input logic [31:0] sh,
                        input logic [63:0] lg, input logic [63:0] init);
        set_beat(first, last, sh, lg, init);
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++;
        if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_vec++;
        if (beat_cnt !== 12'h0) begin n_err++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_single_term();
        beat(1'b1, 1'b1, 32'h03030303, 64'h0005_0005_0005_0005, 64'h0);
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_vec++;
        if (out_data !== 64'h000F_000F_000F_000F) begin
            n_err++; $display("FAIL single_data got %h want 000f000f000f000f", out_data);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_negative_wrap();
        // lane0: -1*1; lane1: FFFF + 2*1 wraps; lane2: -128*1; lane3: 0
        beat(1'b1, 1'b1, 32'h00_80_02_FF, 64'h0001_0001_0001_0001, 64'h0000_0000_FFFF_0000);
        n_vec++;
        if (out_data !== 64'h0000_FF80_0001_FFFF) begin
            n_err++; $display("FAIL neg_wrap_q16 got %h want 0000ff800001ffff", out_data);
        end
        n_vec++;
        if (out_data15 !== 64'h0000_7F80_0001_7FFF) begin
            n_err++; $display("FAIL neg_wrap_q15 got %h want 00007f8000017fff", out_data15);
        end
        step();
    endtask

    task automatic test_accumulate();
        beat(1'b1, 1'b0, 32'h00_01_00_00, 64'h0000_0002_0000_0000, 64'h0010_0010_0010_0010);
        n_vec++;
        if (beat_cnt !== 12'd1) begin n_err++; $display("FAIL acc_cnt1 got %0d want 1", beat_cnt); end
        beat(1'b0, 1'b0, 32'h00_02_00_00, 64'h0000_0003_0000_0000, 64'h0);
        n_vec++;
        if (beat_cnt !== 12'd2) begin n_err++; $display("FAIL acc_cnt2 got %0d want 2", beat_cnt); end
        beat(1'b0, 1'b1, 32'h00_03_00_00, 64'h0000_0004_0000_0000, 64'h0);
        n_vec++;
        if (beat_cnt !== 12'd0) begin n_err++; $display("FAIL acc_cnt_last got %0d want 0", beat_cnt); end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 64'h0010_0024_0010_0010) begin
            n_err++; $display("FAIL acc_data got v=%b %h want v=1 0010002400100010", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(1'b1, 1'b1, 32'h01010101, 64'h0002_0002_0002_0002, 64'h0);
        set_beat(1'b1, 1'b0, 32'h01010101, 64'h0003_0003_0003_0003, 64'h0);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            step();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 64'h0002_0002_0002_0002 || beat_cnt !== 12'd0) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got v=%b %h cnt=%0d want v=1 0002000200020002 cnt=0",
                         i, out_valid, out_data, beat_cnt);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || beat_cnt !== 12'd1) begin
            n_err++; $display("FAIL bp_consume got v=%b cnt=%0d want v=0 cnt=1", out_valid, beat_cnt);
        end
        beat(1'b0, 1'b1, 32'h01010101, 64'h0001_0001_0001_0001, 64'h0);
        n_vec++;
        if (out_data !== 64'h0004_0004_0004_0004) begin
            n_err++; $display("FAIL bp_result got %h want 0004000400040004", out_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        beat(1'b1, 1'b1, 32'h02020202, 64'h0002_0002_0002_0002, 64'h0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 64'h0004_0004_0004_0004) begin
            n_err++; $display("FAIL b2b_first got v=%b %h want v=1 0004000400040004", out_valid, out_data);
        end
        beat(1'b1, 1'b1, 32'h01010101, 64'h0007_0007_0007_0007, 64'h0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 64'h0007_0007_0007_0007) begin
            n_err++; $display("FAIL b2b_second got v=%b %h want v=1 0007000700070007", out_valid, out_data);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_clear();
        beat(1'b1, 1'b0, 32'h01010101, 64'h0001_0001_0001_0001, 64'h0);
        beat(1'b0, 1'b0, 32'h01010101, 64'h0001_0001_0001_0001, 64'h0);
        n_vec++;
        if (beat_cnt !== 12'd2) begin n_err++; $display("FAIL clr_pre_cnt got %0d want 2", beat_cnt); end
        set_beat(1'b0, 1'b1, 32'h01010101, 64'h0001_0001_0001_0001, 64'h0);
        start_pos = 1'b1;
        step();
        start_pos = 1'b0;
        in_valid  = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || beat_cnt !== 12'd0 || out_data !== 64'h0) begin
            n_err++; $display("FAIL clr_drop got v=%b cnt=%0d %h want v=0 cnt=0 0", out_valid, beat_cnt, out_data);
        end
        beat(1'b1, 1'b1, 32'h01010101, 64'h0001_0001_0001_0001, 64'h0);
        n_vec++;
        if (out_data !== 64'h0001_0001_0001_0001) begin
            n_err++; $display("FAIL clr_next got %h want 0001000100010001", out_data);
        end
        // done must also flush a result stuck behind backpressure
        out_ready = 1'b0;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 64'h0) begin
            n_err++; $display("FAIL done_clear got v=%b %h want v=0 0", out_valid, out_data);
        end
    endtask

    task automatic test_reset_mid();
        beat(1'b1, 1'b0, 32'h01010101, 64'h0005_0005_0005_0005, 64'h0);
        out_ready = 1'b0;
        beat(1'b0, 1'b1, 32'h01010101, 64'h0005_0005_0005_0005, 64'h0);
        beat(1'b1, 1'b0, 32'h01010101, 64'h0005_0005_0005_0005, 64'h0);
        #2;
        rstn = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || beat_cnt !== 12'd0) begin
            n_err++; $display("FAIL rst_mid got v=%b %h cnt=%0d want all 0", out_valid, out_data, beat_cnt);
        end
        out_ready = 1'b1;
        step();
        rstn = 1'b1;
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_after got %b want 0", out_valid); end
    endtask

    initial begin
        rstn = 1'b0; start_pos = 1'b0; done = 1'b0; in_valid = 1'b0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        short_data_0 = '0; short_data_1 = '0; short_data_2 = '0; short_data_3 = '0;
        long_data_0 = '0; long_data_1 = '0; long_data_2 = '0; long_data_3 = '0;
        init_data = '0;
        test_reset();
        test_single_term();
        test_negative_wrap();
        test_accumulate();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
